// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Valid/ready handshake on both sides; result, borrow and signed overflow held until consumed.
module serial_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;

  logic          x, y, dbit, bnext;
  logic [N:0]    res_shift;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    // Full-subtractor cell on the current LSBs.
    x         = a_q[0];
    y         = b_q[0];
    dbit      = x ^ y ^ br_q;
    bnext     = (~x & y) | (~(x ^ y) & br_q);
    // New difference bit enters at the MSB; works for N=1 without a zero-width slice.
    res_shift = {dbit, res_q} >> 1;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          sa_d    = a[N-1];
          sb_d    = b[N-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bnext;
        res_d = res_shift[N-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = res_shift[N-1:0];
          bout_d  = bnext;
          ovf_d   = (sa_q != sb_q) && (dbit != sa_q);
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
